// File: rtl/abr_masked_adder_pkg.sv
// Shared types and helpers for the masked adder scheduler: share encoding and
// index-width sizing used by the arbiter and the tag pipeline.
package abr_masked_adder_pkg;

    // One Boolean-masked bit: [0] and [1] are the two shares, value = s[0] ^ s[1].
    typedef logic [1:0] share_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/abr_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last-granted index,
// wrapping around; the pointer moves only on an accepted grant.
module abr_rr_arbiter
    import abr_masked_adder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic [N-1:0]              req_i,
    input  logic                      advance_i,
    output logic [N-1:0]              gnt_o,
    output logic [idx_width(N)-1:0]   idx_o,
    output logic                      any_o
);

    localparam int IW = idx_width(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] cand;

    // Search starts one past the pointer so the last winner has lowest priority.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr_q) + i) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IW'(N - 1);
        end else if (clear_i) begin
            ptr_q <= IW'(N - 1);
        end else if (advance_i) begin
            ptr_q <= idx_o;
        end
    end

endmodule

// File: rtl/abr_masked_adder_sched.sv
// Shares one pipelined masked Boolean adder among NUM_REQ requesters, tracking
// each issue with a tag so the result is routed back to its originator.
module abr_masked_adder_sched
    import abr_masked_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LATENCY = WIDTH + 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  zeroize_i,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0][1:0]    req_x_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0][1:0]    req_y_i,
    input  logic                                  rnd_valid_i,
    input  logic [WIDTH-1:0]                      rnd_i,
    output logic                                  rnd_ready_o,
    output logic [WIDTH-1:0][1:0]                 add_x_o,
    output logic [WIDTH-1:0][1:0]                 add_y_o,
    output logic [WIDTH-1:0]                      add_rnd_o,
    output logic                                  add_zeroize_o,
    input  logic [WIDTH-1:0][1:0]                 add_s_i,
    output logic [NUM_REQ-1:0]                    rsp_valid_o,
    output logic [WIDTH-1:0][1:0]                 rsp_s_o,
    output logic                                  busy_o,
    output logic                                  rnd_err_o
);

    localparam int IDW = idx_width(NUM_REQ);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    tag_t [LATENCY-1:0]  tag_q;
    tag_t [LATENCY-1:0]  tag_d;
    logic                rnd_err_q;
    logic                rnd_err_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDW-1:0]      arb_idx;
    logic                arb_any;
    logic                active;
    logic                issue;
    logic                pipe_busy;
    share_t [WIDTH-1:0]  op_x;
    share_t [WIDTH-1:0]  op_y;

    // Zeroize and reset both suppress issue so no new tag slips in while clearing.
    assign active = rst_n & ~zeroize_i;
    assign issue  = active & rnd_valid_i & arb_any;

    abr_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (zeroize_i),
        .req_i     (req_valid_i),
        .advance_i (issue),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .any_o     (arb_any)
    );

    assign req_ready_o   = issue ? arb_gnt : '0;
    assign op_x          = req_x_i[arb_idx];
    assign op_y          = req_y_i[arb_idx];
    assign add_x_o       = issue ? op_x : '0;
    assign add_y_o       = issue ? op_y : '0;
    assign add_rnd_o     = rnd_valid_i ? rnd_i : '0;
    assign add_zeroize_o = zeroize_i;

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            pipe_busy = pipe_busy | tag_q[i].vld;
        end
    end

    assign busy_o      = pipe_busy | issue;
    assign rnd_ready_o = rnd_valid_i & busy_o;
    assign rnd_err_d   = rnd_err_q | (pipe_busy & ~rnd_valid_i);
    assign rnd_err_o   = rnd_err_q;

    always_comb begin
        tag_d[0].vld = issue;
        tag_d[0].id  = arb_idx;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            rnd_err_q <= 1'b0;
        end else if (zeroize_i) begin
            tag_q     <= '0;
            rnd_err_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            rnd_err_q <= rnd_err_d;
        end
    end

    // The exiting tag lines up with the adder output for the op issued LATENCY cycles ago.
    always_comb begin
        rsp_valid_o = '0;
        rsp_s_o     = '0;
        if (tag_q[LATENCY-1].vld && !zeroize_i) begin
            rsp_valid_o[tag_q[LATENCY-1].id] = 1'b1;
            rsp_s_o                          = add_s_i;
        end
    end

endmodule

// File: tb/tb_abr_masked_adder_sched.sv
// Directed bench for the masked adder scheduler with a behavioural stand-in
// adder of the same latency and a response scoreboard.
module tb_abr_masked_adder_sched;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int LAT     = WIDTH + 2;

    typedef logic [WIDTH-1:0][1:0] shares_t;

    typedef struct {
        int         due;
        int         idx;
        logic [7:0] sum;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       zeroize = 1'b0;
    logic [NUM_REQ-1:0]         reqValid = '0;
    logic [NUM_REQ-1:0]         reqReady;
    logic [NUM_REQ-1:0][WIDTH-1:0][1:0] reqX = '0;
    logic [NUM_REQ-1:0][WIDTH-1:0][1:0] reqY = '0;
    logic                       rndValid = 1'b0;
    logic [WIDTH-1:0]           rnd = '0;
    logic                       rndReady;
    shares_t                    addX;
    shares_t                    addY;
    logic [WIDTH-1:0]           addRnd;
    logic                       addZeroize;
    shares_t                    addS;
    logic [NUM_REQ-1:0]         rspValid;
    shares_t                    rspS;
    logic                       busy;
    logic                       rndErr;

    int          checkCount = 0;
    int          errorCount = 0;
    int          cyc = 0;
    logic [7:0]  opX [NUM_REQ];
    logic [7:0]  opY [NUM_REQ];
    exp_t        expQ [$];
    shares_t     pipeS [LAT];
    logic [3:0]  monExpV;
    logic [7:0]  monExpS;
    logic [7:0]  monSum;
    logic [3:0]  rspSeen;

    abr_masked_adder_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .zeroize_i     (zeroize),
        .req_valid_i   (reqValid),
        .req_ready_o   (reqReady),
        .req_x_i       (reqX),
        .req_y_i       (reqY),
        .rnd_valid_i   (rndValid),
        .rnd_i         (rnd),
        .rnd_ready_o   (rndReady),
        .add_x_o       (addX),
        .add_y_o       (addY),
        .add_rnd_o     (addRnd),
        .add_zeroize_o (addZeroize),
        .add_s_i       (addS),
        .rsp_valid_o   (rspValid),
        .rsp_s_o       (rspS),
        .busy_o        (busy),
        .rnd_err_o     (rndErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic shares_t split(input logic [7:0] v, input logic [7:0] m);
        shares_t s;
        for (int i = 0; i < WIDTH; i++) begin
            s[i][0] = v[i] ^ m[i];
            s[i][1] = m[i];
        end
        return s;
    endfunction

    function automatic logic [7:0] unmask(input shares_t s);
        logic [7:0] v;
        for (int i = 0; i < WIDTH; i++) begin
            v[i] = s[i][0] ^ s[i][1];
        end
        return v;
    endfunction

    // Stand-in adder: unmasked sum, re-masked with a fresh split, LAT cycles deep.
    always @(posedge clk) begin
        pipeS[0] <= split(8'(unmask(addX) + unmask(addY)), 8'($urandom));
        for (int i = 1; i < LAT; i++) begin
            pipeS[i] <= pipeS[i-1];
        end
    end
    assign addS = pipeS[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checkCount++;
        if (got !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expected, cyc);
        end
    endtask

    task automatic setOperands(input int k, input logic [7:0] x, input logic [7:0] y);
        opX[k] = x;
        opY[k] = y;
        reqX[k] = split(x, 8'($urandom));
        reqY[k] = split(y, 8'($urandom));
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic rv, input logic zer);
        @(posedge clk);
        #1;
        reqValid = valid;
        rndValid = rv;
        zeroize  = zer;
        rnd      = 8'($urandom);
    endtask

    // Scoreboard: every grant expects exactly one response LAT cycles later.
    always @(negedge clk) begin
        if (!rst_n || zeroize) expQ.delete();
        while (expQ.size() > 0 && expQ[0].due < cyc) void'(expQ.pop_front());
        monExpV = '0;
        monExpS = '0;
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            monExpV = 4'(1 << expQ[0].idx);
            monExpS = expQ[0].sum;
            void'(expQ.pop_front());
        end
        checkOutput("rsp_valid", 32'(rspValid), 32'(monExpV));
        if (monExpV != 0) checkOutput("rsp_sum", 32'(unmask(rspS)), 32'(monExpS));
        else checkOutput("rsp_s_idle", 32'(rspS), 32'd0);
        checkOutput("ready_onehot", 32'($onehot0(reqReady)), 32'd1);
        checkOutput("add_rnd", 32'(addRnd), rndValid ? 32'(rnd) : 32'd0);
        if (reqReady == 0) begin
            checkOutput("add_x_idle", 32'(addX), 32'd0);
            checkOutput("add_y_idle", 32'(addY), 32'd0);
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (reqReady[k]) begin
                    monSum = opX[k] + opY[k];
                    expQ.push_back('{cyc + LAT, k, monSum});
                    checkOutput("add_x_grant", 32'(unmask(addX)), 32'(opX[k]));
                    checkOutput("add_y_grant", 32'(unmask(addY)), 32'(opY[k]));
                end
            end
        end
    end

    task automatic runSingleOp(input logic [7:0] x, input logic [7:0] y, input logic [3:0] mask,
                               input logic [7:0] expSum);
        setOperands(0, x, y);
        applyStimulus(mask, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("single_grant", 32'(reqReady), 32'h1);
        checkOutput("single_rnd_ready", 32'(rndReady), 32'h1);
        for (int i = 1; i < LAT; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("single_early", 32'(rspValid), 32'h0);
        end
        applyStimulus(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("single_rsp_valid", 32'(rspValid), 32'h1);
        checkOutput("single_rsp_sum", 32'(unmask(rspS)), 32'(expSum));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
        end
    endtask

    initial begin
        for (int k = 0; k < NUM_REQ; k++) setOperands(k, 8'h00, 8'h00);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 32'(reqReady), 32'h0);
        checkOutput("reset_rsp", 32'(rspValid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_rnd_err", 32'(rndErr), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Scenario 1: single op from requester 0
        $display("[TB] single op");
        runSingleOp(8'h5A, 8'h3C, 4'b0001, 8'h96);

        // Scenario 2: all requesters valid; last grant was 0 so rotation starts at 1
        $display("[TB] round robin");
        setOperands(0, 8'h10, 8'h20);
        setOperands(1, 8'h33, 8'h44);
        setOperands(2, 8'h80, 8'h90);
        setOperands(3, 8'hC3, 8'h7E);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("rr_grant", 32'(reqReady), 32'(1 << ((1 + i) % 4)));
        end
        drain(LAT + 2);
        @(negedge clk);
        checkOutput("rr_no_rnd_err", 32'(rndErr), 32'h0);
        checkOutput("rr_idle", 32'(busy), 32'h0);

        // Scenario 3: randomness starved with 3 ops in flight
        $display("[TB] rnd starvation");
        applyStimulus(4'b0110, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("starve_grant0", 32'(reqReady), 32'h2);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("starve_grant1", 32'(reqReady), 32'h4);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("starve_grant2", 32'(reqReady), 32'h2);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("starve_no_grant", 32'(reqReady), 32'h0);
        checkOutput("starve_rnd_ready", 32'(rndReady), 32'h0);
        checkOutput("starve_busy", 32'(busy), 32'h1);
        checkOutput("starve_err_pre", 32'(rndErr), 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("starve_err_set", 32'(rndErr), 32'h1);
        drain(LAT + 2);
        @(negedge clk);
        checkOutput("starve_err_sticky", 32'(rndErr), 32'h1);

        // Scenario 4: zeroize drops in-flight ops and restarts rotation at 0
        $display("[TB] zeroize");
        applyStimulus(4'b1100, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("zero_grant0", 32'(reqReady), 32'h4);
        applyStimulus(4'b1100, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("zero_grant1", 32'(reqReady), 32'h8);
        drain(3);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("zero_add_zeroize", 32'(addZeroize), 32'h1);
        checkOutput("zero_no_grant", 32'(reqReady), 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("zero_err_clear", 32'(rndErr), 32'h0);
        checkOutput("zero_busy", 32'(busy), 32'h0);
        rspSeen = '0;
        for (int i = 0; i < LAT; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            @(negedge clk);
            rspSeen = rspSeen | rspValid;
        end
        checkOutput("zero_dropped", 32'(rspSeen), 32'h0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("zero_rr_restart", 32'(reqReady), 32'h1);
        drain(LAT + 2);

        // Scenario 5: asynchronous reset mid-stream
        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("rst_pre_grant", 32'(reqReady), 32'(1 << (i + 1)));
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_ready", 32'(reqReady), 32'h0);
        checkOutput("rst_async_rsp", 32'(rspValid), 32'h0);
        checkOutput("rst_async_busy", 32'(busy), 32'h0);
        checkOutput("rst_async_addx", 32'(addX), 32'h0);
        checkOutput("rst_async_rnd_ready", 32'(rndReady), 32'h0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rst_held_ready", 32'(reqReady), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reqValid = '0;
        runSingleOp(8'h5A, 8'h3C, 4'b1111, 8'h96);

        // Scenario 6: overflow wraps mod 2^WIDTH; idle adder inputs stay zero
        $display("[TB] overflow");
        runSingleOp(8'hFF, 8'h01, 4'b0001, 8'h00);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("idle_add_x", 32'(addX), 32'h0);
        checkOutput("idle_add_y", 32'(addY), 32'h0);
        checkOutput("idle_busy", 32'(busy), 32'h0);
        checkOutput("idle_rnd_err", 32'(rndErr), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
